tpsram_verify_reader: RTL
=========================

TPSRAM_VERIFY_READER -- requirements
Module: tpsram_verify_reader

Interface
REQ-001 The block SHALL have these parameters:
- DEPTH, default 64: number of words checked.
- ADDR_W, default 6: width of the read address.
- DATA_W, default 8: width of the read data.
- RD_LAT, default 1: TPSRAM read latency in cycles; the legal values are 1 and 2.
- SEED, default 8'hA5: pattern seed.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1: the single clock.
- RESET, in, 1: synchronous, active-high reset.
- i_start, in, 1: starts one verify pass when the block is idle.
- i_TPSRAM_RD_sv, in, DATA_W: read data from the TPSRAM RD port.
- o_TPSRAM_RADDR_sv, out, ADDR_W: read address to the TPSRAM.
- o_TPSRAM_REN, out, 1: read enable to the TPSRAM.
- o_busy, out, 1: a pass is in progress.
- o_done, out, 1: one-cycle pulse at the end of a pass.
- o_pass, out, 1: every word of the last pass matched.
- o_fail_addr, out, ADDR_W: address of the first mismatch in the last pass.
- o_err_count, out, ADDR_W+1: number of mismatches in the last pass.
- o_restart_req, out, 1: one-cycle pulse requesting a device restart.

REQ-003 The block SHALL use one clock, CLK, and a synchronous, active-high reset, RESET; every register SHALL update only on the rising edge of CLK.

Function
REQ-004 The expected word at address a SHALL be (a zero-extended to DATA_W + SEED) mod 2^DATA_W, so address 0 expects 8'hA5 and address 63 expects 8'hE4.
REQ-005 The FSM SHALL have four states: IDLE, READ, DRAIN and DONE.
REQ-006 In IDLE, i_start=1 in cycle T SHALL cause the following in cycle T+1:
- state = READ;
- o_busy=1;
- o_TPSRAM_REN=1;
- o_TPSRAM_RADDR_sv=0;
- the error counter, the first-fail flag and o_fail_addr are cleared.
REQ-007 In READ, the block SHALL assert o_TPSRAM_REN and increment the address by 1 each cycle, issuing addresses 0..DEPTH-1 in DEPTH consecutive cycles (T+1..T+DEPTH) with no gaps.
REQ-008 After the read of address DEPTH-1 is issued, the FSM SHALL move to DRAIN for exactly RD_LAT cycles, with o_TPSRAM_REN=0 and o_TPSRAM_RADDR_sv held at DEPTH-1.
REQ-009 A read issued in cycle k SHALL be compared against i_TPSRAM_RD_sv in cycle k+RD_LAT, using a RD_LAT-deep valid/address delay line; the address is never re-derived from the current counter.
REQ-010 On each mismatch:
- o_err_count SHALL increment by 1; it cannot overflow, since the maximum is DEPTH = 64 and the counter has 7 bits;
- on the first mismatch of a pass only, o_fail_addr SHALL capture the delayed address.
REQ-011 After DRAIN, the FSM SHALL spend one cycle in DONE with the following values:
- o_done=1;
- o_busy=0;
- o_pass=1 if and only if o_err_count=0;
- o_restart_req=1 if and only if o_err_count≠0.
It SHALL then return to IDLE.
REQ-012 For a start in cycle T, o_done SHALL be high in cycle T+DEPTH+RD_LAT+1; with the defaults this is T+66.
REQ-013 i_start SHALL be ignored in READ, DRAIN and DONE; it is sampled only in IDLE, so a start held high for 2 or more cycles launches a single pass.
REQ-014 i_start asserted in the IDLE cycle that immediately follows DONE SHALL start a new pass; back-to-back passes are legal.
REQ-015 o_pass, o_fail_addr and o_err_count SHALL hold their values from DONE until the next start or reset; o_fail_addr SHALL be 0 when o_pass=1.
REQ-016 o_TPSRAM_REN SHALL be 0 in every state except READ.
REQ-017 X on i_TPSRAM_RD_sv outside a compare cycle SHALL NOT affect any output.

Reset
REQ-018 RESET=1 sampled on a rising edge SHALL force the following state in the next cycle:
- state = IDLE;
- o_TPSRAM_REN=0, o_TPSRAM_RADDR_sv=0;
- o_busy=0, o_done=0;
- o_pass=0, o_fail_addr=0, o_err_count=0;
- o_restart_req=0;
- the delay line is cleared.
REQ-019 RESET asserted mid-pass (READ or DRAIN) SHALL abort the pass with no o_done or o_restart_req pulse; in-flight reads SHALL be discarded.
REQ-020 RESET has priority over i_start in the same cycle.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Clean pass: RAM preloaded per REQ-004, RD_LAT=1, start at T -> REN high for cycles T+1..T+64, o_done at T+66, o_pass=1, o_err_count=0, no o_restart_req.
- Single error: word 17 = 8'h00 (expected 8'hB6) -> o_pass=0, o_err_count=1, o_fail_addr=17, o_restart_req pulses with o_done.
- Multiple errors: words 5, 40 and 63 corrupted -> o_err_count=3, o_fail_addr=5.
- All words wrong (RAM all 8'hFF except the matching address 90 decimal is out of range, so 64 errors) -> o_err_count=64, o_fail_addr=0.
- RD_LAT=2: clean RAM -> o_done at T+67, o_pass=1; corrupt word 0 -> o_fail_addr=0, confirming alignment at the first address.
- Reset at T+30 mid-READ -> next cycle all outputs are 0 and no o_done; a later start yields a full 64-read pass with correct results.
- Start held high for 100 cycles -> exactly one o_done per 66-cycle window, with passes re-launching from IDLE.

Source files
------------

// File: rtl/tpsram_verify_reader.sv
`default_nettype none
// ============================================================================
// Module   : tpsram_verify_reader
// Purpose  : Reads DEPTH words from a TPSRAM and checks each word against an
//            address+SEED pattern, reporting pass/fail and the error count.
// Revision : 1.0 - initial release
// ============================================================================
module tpsram_verify_reader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int SEED   = 8'hA5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_TPSRAM_RD_sv,
    output logic [ADDR_W-1:0] o_TPSRAM_RADDR_sv,
    output logic              o_TPSRAM_REN,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [ADDR_W:0]   o_err_count,
    output logic              o_restart_req
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        c_drain_last = 2'(RD_LAT - 1);
    localparam logic [DATA_W-1:0] c_seed       = DATA_W'(SEED);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          drain_cnt_q, drain_cnt_d;
    logic [RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;
    logic [ADDR_W-1:0]   addr_pipe_q [RD_LAT];
    logic [ADDR_W-1:0]   addr_pipe_d [RD_LAT];
    logic [ADDR_W:0]     err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic                first_fail_q, first_fail_d;
    logic                pass_q, pass_d;
    logic                done_q, done_d;
    logic                restart_q, restart_d;

    logic                cmp_vld;
    logic [ADDR_W-1:0]   cmp_addr;
    logic [DATA_W-1:0]   cmp_expected;
    logic                mismatch;

    // The compare address travels with the read through the delay line, so
    // returned data is always judged against the address that produced it.
    assign cmp_vld      = vld_pipe_q[RD_LAT-1];
    assign cmp_addr     = addr_pipe_q[RD_LAT-1];
    assign cmp_expected = DATA_W'(cmp_addr) + c_seed;
    assign mismatch     = cmp_vld && (i_TPSRAM_RD_sv != cmp_expected);

    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        vld_pipe_d[0]  = (state_q == READ);
        addr_pipe_d[0] = addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            addr_pipe_d[i] = addr_pipe_q[i-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        drain_cnt_d  = drain_cnt_q;
        err_cnt_d    = err_cnt_q;
        fail_addr_d  = fail_addr_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        done_d       = 1'b0;
        restart_d    = 1'b0;

        if (mismatch) begin
            err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
            if (!first_fail_q) begin
                first_fail_d = 1'b1;
                fail_addr_d  = cmp_addr;
            end
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d      = READ;
                    addr_d       = '0;
                    err_cnt_d    = '0;
                    fail_addr_d  = '0;
                    first_fail_d = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            READ: begin
                if (addr_q == c_last_addr) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 2'd0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // The final compare lands in the last drain cycle, so the
                // verdict uses the count including that compare.
                if (drain_cnt_q == c_drain_last) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    pass_d    = (err_cnt_d == '0);
                    restart_d = (err_cnt_d != '0);
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            drain_cnt_q  <= 2'd0;
            vld_pipe_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_pipe_q[i] <= '0;
            end
            err_cnt_q    <= '0;
            fail_addr_q  <= '0;
            first_fail_q <= 1'b0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            drain_cnt_q  <= drain_cnt_d;
            vld_pipe_q   <= vld_pipe_d;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_pipe_q[i] <= addr_pipe_d[i];
            end
            err_cnt_q    <= err_cnt_d;
            fail_addr_q  <= fail_addr_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
            restart_q    <= restart_d;
        end
    end

    assign o_TPSRAM_RADDR_sv = addr_q;
    assign o_TPSRAM_REN      = (state_q == READ);
    assign o_busy            = (state_q == READ) || (state_q == DRAIN);
    assign o_done            = done_q;
    assign o_pass            = pass_q;
    assign o_fail_addr       = fail_addr_q;
    assign o_err_count       = err_cnt_q;
    assign o_restart_req     = restart_q;

endmodule
`default_nettype wire
